// File: rtl/dmem_hex_dumper.sv
// dmem_hex_dumper: dumps a data-memory word range as ASCII hex lines over an 8N1 UART
module dmem_hex_dumper #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [10:0] START_ADDR   = 11'h000,
    parameter logic [10:0] END_ADDR     = 11'h7FF
) (
    input  logic        CLK,
    input  logic        nrst,
    input  logic        start,
    input  logic [31:0] con_data,
    output logic [10:0] con_addr,
    output logic        TX,
    output logic        busy,
    output logic        done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, LOAD, SHIFT, NEXT} state_t;
    state_t state, state_n;
    logic [10:0] addr_n;
    logic [31:0] word, word_n;
    logic [3:0] chr, chr_n, bit_cnt, bit_n, nib;
    logic [BW-1:0] baud, baud_n;
    logic [8:0] sh, sh_n;
    logic [7:0] ascii;
    logic tx_n, done_n, baud_end;
    assign busy = state != IDLE;
    assign baud_end = baud == BW'(CLKS_PER_BIT - 1);
    assign nib = word[{~chr[2:0], 2'b00} +: 4];
    assign ascii = chr == 4'd8 ? 8'h0D :
                   chr == 4'd9 ? 8'h0A :
                   nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    always_comb begin
        state_n = state;
        addr_n  = con_addr;
        word_n  = word;
        chr_n   = chr;
        bit_n   = bit_cnt;
        baud_n  = baud;
        sh_n    = sh;
        tx_n    = TX;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                addr_n = START_ADDR;
                if (start && !done) state_n = FETCH;
            end
            FETCH: state_n = LATCH;
            LATCH: begin
                word_n  = con_data;
                chr_n   = 4'd0;
                state_n = LOAD;
            end
            LOAD: begin
                sh_n    = {1'b1, ascii};
                tx_n    = 1'b0;
                bit_n   = 4'd0;
                baud_n  = '0;
                state_n = SHIFT;
            end
            SHIFT: begin
                baud_n = baud_end ? '0 : baud + BW'(1);
                if (baud_end && bit_cnt == 4'd9) begin
                    chr_n   = chr + 4'd1;
                    state_n = chr == 4'd9 ? NEXT : LOAD;
                end else if (baud_end) begin
                    tx_n  = sh[0];
                    sh_n  = {1'b0, sh[8:1]};
                    bit_n = bit_cnt + 4'd1;
                end
            end
            NEXT: begin
                if (con_addr == END_ADDR) begin
                    done_n  = 1'b1;
                    addr_n  = START_ADDR;
                    state_n = IDLE;
                end else begin
                    addr_n  = con_addr + 11'd1;
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!nrst) begin
            state    <= IDLE;
            con_addr <= START_ADDR;
            word     <= '0;
            chr      <= '0;
            bit_cnt  <= '0;
            baud     <= '0;
            sh       <= '1;
            TX       <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            con_addr <= addr_n;
            word     <= word_n;
            chr      <= chr_n;
            bit_cnt  <= bit_n;
            baud     <= baud_n;
            sh       <= sh_n;
            TX       <= tx_n;
            done     <= done_n;
        end
    end
endmodule

// File: tb/tb_dmem_hex_dumper.sv
// tb_dmem_hex_dumper: directed UART-decoding bench over three address-range configurations
module tb_dmem_hex_dumper;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic [2:0] st = 3'b000;
    logic [31:0] cd0, cd1, cd2;
    logic [10:0] ca0, ca1, ca2, cas;
    logic tx0, tx1, tx2, bz0, bz1, bz2, dn0, dn1, dn2, txs, bzs, dns;
    int sel = 0;
    int nvec = 0;
    int nerr = 0;
    int dcnt [3] = '{0, 0, 0};

    typedef struct {
        int          sel;
        logic [10:0] sa;
        string       exp;
        bit          again;
    } vec_t;
    vec_t v [4];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [10:0] a);
        case (a)
            11'h000: return 32'hDEADBEEF;
            11'h003: return 32'h00000000;
            11'h004: return 32'h0123ABCD;
            11'h005: return 32'hFFFFFFFF;
            11'h7FF: return 32'h89ABCDEF;
            default: return 32'h5A5A5A5A;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        cd0 <= mem(ca0);
        cd1 <= mem(ca1);
        cd2 <= mem(ca2);
    end

    always @(negedge clk) begin
        if (dn0) dcnt[0]++;
        if (dn1) dcnt[1]++;
        if (dn2) dcnt[2]++;
    end

    always_comb begin
        txs = sel == 0 ? tx0 : sel == 1 ? tx1 : tx2;
        bzs = sel == 0 ? bz0 : sel == 1 ? bz1 : bz2;
        dns = sel == 0 ? dn0 : sel == 1 ? dn1 : dn2;
        cas = sel == 0 ? ca0 : sel == 1 ? ca1 : ca2;
    end

    dmem_hex_dumper #(.CLKS_PER_BIT(4), .START_ADDR(11'h000), .END_ADDR(11'h000)) d0 (
        .CLK(clk), .nrst(nrst), .start(st[0]), .con_data(cd0), .con_addr(ca0),
        .TX(tx0), .busy(bz0), .done(dn0));
    dmem_hex_dumper #(.CLKS_PER_BIT(4), .START_ADDR(11'h003), .END_ADDR(11'h005)) d1 (
        .CLK(clk), .nrst(nrst), .start(st[1]), .con_data(cd1), .con_addr(ca1),
        .TX(tx1), .busy(bz1), .done(dn1));
    dmem_hex_dumper #(.CLKS_PER_BIT(4), .START_ADDR(11'h7FF), .END_ADDR(11'h7FF)) d2 (
        .CLK(clk), .nrst(nrst), .start(st[2]), .con_data(cd2), .con_addr(ca2),
        .TX(tx2), .busy(bz2), .done(dn2));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Detect a start bit, then sample each bit 2 clocks into its 4-clock cell.
    task automatic rx_byte(output logic [7:0] b, output logic ok);
        int t = 0;
        ok = 1'b1;
        b = 8'h00;
        while (txs !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            ok = 1'b0;
            return;
        end
        repeat (2) @(negedge clk);
        if (txs !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            b[i] = txs;
        end
        repeat (4) @(negedge clk);
        if (txs !== 1'b1) ok = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        st[sel] = 1'b1;
        @(negedge clk);
        st[sel] = 1'b0;
    endtask

    task automatic rx_string(input string exp, input logic [10:0] sa);
        logic [7:0] b;
        logic ok;
        for (int i = 0; i < exp.len(); i++) begin
            rx_byte(b, ok);
            chk("frame_ok", {31'd0, ok}, 32'd1);
            if (!ok) break;
            chk("char", {24'd0, b}, {24'd0, exp[i]});
            chk("addr_word", {21'd0, cas}, {21'd0, sa} + i / 10);
        end
    endtask

    initial begin
        int d_before;
        int lows;
        int t;
        v[0] = '{0, 11'h000, "DEADBEEF\r\n", 1'b0};
        v[1] = '{1, 11'h003, "00000000\r\n0123ABCD\r\nFFFFFFFF\r\n", 1'b0};
        v[2] = '{2, 11'h7FF, "89ABCDEF\r\n", 1'b0};
        v[3] = '{1, 11'h003, "00000000\r\n0123ABCD\r\nFFFFFFFF\r\n", 1'b1};

        st = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", {31'd0, tx0}, 32'd1);
            chk("rst_busy", {31'd0, bz0}, 32'd0);
            chk("rst_done", {31'd0, dn0}, 32'd0);
            chk("rst_addr", {21'd0, ca0}, 32'd0);
        end
        st = 3'b000;
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_tx", {31'd0, tx0}, 32'd1);

        for (int k = 0; k < 4; k++) begin
            sel = v[k].sel;
            d_before = dcnt[sel];
            pulse_start();
            chk("busy_start", {31'd0, bzs}, 32'd1);
            if (v[k].again) begin
                fork
                    begin
                        repeat (200) @(negedge clk);
                        st[sel] = 1'b1;
                        @(negedge clk);
                        st[sel] = 1'b0;
                    end
                join_none
            end
            rx_string(v[k].exp, v[k].sa);
            repeat (6) @(negedge clk);
            chk("done_count", dcnt[sel] - d_before, 32'd1);
            chk("busy_end", {31'd0, bzs}, 32'd0);
            chk("addr_idle", {21'd0, cas}, {21'd0, v[k].sa});
            lows = 0;
            repeat (60) begin
                @(negedge clk);
                if (txs !== 1'b1) lows++;
            end
            chk("tx_idle", lows, 32'd0);
            chk("done_total", dcnt[sel] - d_before, 32'd1);
        end

        sel = 0;
        pulse_start();
        rx_string("DEAD", 11'h000);
        t = 0;
        while (txs !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("char4_start", {31'd0, t < 100}, 32'd1);
        repeat (10) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        chk("abort_tx", {31'd0, txs}, 32'd1);
        chk("abort_busy", {31'd0, bzs}, 32'd0);
        chk("abort_addr", {21'd0, cas}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        d_before = dcnt[0];
        pulse_start();
        rx_string("DEADBEEF\r\n", 11'h000);
        repeat (6) @(negedge clk);
        chk("restart_done", dcnt[0] - d_before, 32'd1);
        chk("restart_busy", {31'd0, bzs}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
